bcd_stopwatch_ctrl: RTL

//  Run/pause/clear sequencer for a chain of DIGITS synchronous BCD decade stages (0-9 each).
//  A clk prescaler produces count ticks; the FSM gates the ticks and cascades carries digit to digit.

---
 rtl/bcd_pkg.sv | 26 ++
 rtl/bcd_stopwatch_ctrl_if.sv | 24 ++
 rtl/bcd_stopwatch_ctrl_digit.sv | 29 ++
 rtl/bcd_stopwatch_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants for the BCD stopwatch: FSM state encoding, digit width and
// the decade increment helper used by each stage.
package bcd_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_RUN   = 2'd1;
    localparam state_t S_PAUSE = 2'd2;

    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    // Any value at or above 9 folds back to 0, so an illegal code self-heals.
    function automatic logic [DIGIT_W-1:0] bcd_inc(input logic [DIGIT_W-1:0] q);
        logic [DIGIT_W-1:0] r;
        if (q >= BCD_MAX) begin
            r = 4'd0;
        end else begin
            r = q + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_stopwatch_ctrl_if.sv
// Command/status bundle between push-button logic, the stopwatch and the display driver.
interface bcd_stopwatch_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  cmd_start;
    logic                  cmd_stop;
    logic                  cmd_clear;
    logic                  cmd_lap;
    logic                  running;
    logic                  tick;
    logic [4*DIGITS-1:0]   count;
    logic [4*DIGITS-1:0]   display;
    logic                  overflow;

    modport master (
        output cmd_start, cmd_stop, cmd_clear, cmd_lap,
        input  running, tick, count, display, overflow
    );

    modport slave (
        input  cmd_start, cmd_stop, cmd_clear, cmd_lap,
        output running, tick, count, display, overflow
    );
endinterface

// File: rtl/bcd_stopwatch_ctrl_digit.sv
// One synchronous BCD decade stage (0-9); clear has priority over increment.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               inc,
    output logic [DIGIT_W-1:0] q,
    output logic               at_max
);

    logic [DIGIT_W-1:0] r_q;

    // Decade register: reset/clear to zero, otherwise step on inc.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_q <= 4'd0;
        end else if (inc) begin
            r_q <= bcd_inc(r_q);
        end else begin
            r_q <= r_q;
        end
    end

    assign q      = r_q;
    assign at_max = (r_q == BCD_MAX);

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Run/pause/clear sequencer with prescaler and a cascaded BCD counter.
// Optional lap-hold display freeze is built when LAP_HOLD_EN is defined.
module bcd_stopwatch_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 10
)(
    input  logic                 clk,
    input  logic                 reset,
    bcd_stopwatch_ctrl_if.slave  bus
);

    localparam int             PW         = $clog2(PRESCALE);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESCALE - 1);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      w_running;
    logic [PW-1:0]             r_presc;
    logic                      w_tick;
    logic                      r_overflow;
    logic [4*DIGITS-1:0]       w_count;
    logic [DIGITS-1:0]         w_at_max;
    logic [DIGITS:0]           w_carry;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state; clear beats stop, stop beats start.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.cmd_clear) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_stop) begin
                        w_state_nxt = S_IDLE;
                    end else if (bus.cmd_start) begin
                        w_state_nxt = S_RUN;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_RUN: begin
                    if (bus.cmd_stop) begin
                        w_state_nxt = S_PAUSE;
                    end else begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_PAUSE: begin
                    if (bus.cmd_stop) begin
                        w_state_nxt = S_PAUSE;
                    end else if (bus.cmd_start) begin
                        w_state_nxt = S_RUN;
                    end else begin
                        w_state_nxt = S_PAUSE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // FSM outputs, decoded from the state register.
    always_comb begin
        w_running = 1'b0;
        case (r_state)
            S_RUN:   w_running = 1'b1;
            default: w_running = 1'b0;
        endcase
    end

    assign w_tick = w_running && (r_presc == PRESC_LAST);

    // Prescaler: advances only while running, held through PAUSE so a resume
    // finishes the partial period.
    always_ff @(posedge clk) begin
        if (reset || bus.cmd_clear || (r_state == S_IDLE)) begin
            r_presc <= '0;
        end else if (w_running) begin
            if (r_presc == PRESC_LAST) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end else begin
            r_presc <= r_presc;
        end
    end

    // Ripple-free carry: a stage steps when every lower stage sits at 9.
    assign w_carry[0] = w_tick;
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        bcd_digit u_digit (
            .clk    (clk),
            .reset  (reset),
            .clr    (bus.cmd_clear),
            .inc    (w_carry[gi]),
            .q      (w_count[4*gi +: 4]),
            .at_max (w_at_max[gi])
        );
        assign w_carry[gi+1] = w_carry[gi] & w_at_max[gi];
    end

    // Sticky wrap flag: carry out of the top digit means all-9s rolled to 0.
    always_ff @(posedge clk) begin
        if (reset || bus.cmd_clear) begin
            r_overflow <= 1'b0;
        end else if (w_carry[DIGITS]) begin
            r_overflow <= 1'b1;
        end else begin
            r_overflow <= r_overflow;
        end
    end

`ifdef LAP_HOLD_EN
    logic                r_hold;
    logic [4*DIGITS-1:0] r_snap;

    // Lap toggle: freezes the pre-edge count for the display while count keeps going.
    always_ff @(posedge clk) begin
        if (reset || bus.cmd_clear) begin
            r_hold <= 1'b0;
            r_snap <= '0;
        end else if (bus.cmd_lap && (r_state != S_IDLE)) begin
            r_hold <= ~r_hold;
            r_snap <= w_count;
        end else begin
            r_hold <= r_hold;
            r_snap <= r_snap;
        end
    end

    assign bus.display = r_hold ? r_snap : w_count;
`else
    logic w_unused_lap;
    assign w_unused_lap = bus.cmd_lap;
    assign bus.display  = w_count;
`endif

    assign bus.running  = w_running;
    assign bus.tick     = w_tick;
    assign bus.count    = w_count;
    assign bus.overflow = r_overflow;

endmodule
